// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - address map, button indices and LFSR step for the data-memory responder
package dmem_pkg;

    localparam logic [7:0] RAM_TOP    = 8'hEF;
    localparam logic [7:0] A_BTN_STAT = 8'hF0;
    localparam logic [7:0] A_BTN_LVL  = 8'hF1;
    localparam logic [7:0] A_RAND     = 8'hF2;
    localparam logic [7:0] A_TIMER    = 8'hF3;
    localparam logic [7:0] A_LED      = 8'hF4;
    localparam logic [7:0] A_CURSOR   = 8'hF5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_CTR   = 4;
    localparam int NBTN      = BTN_CTR + 1;

    // Maximal-length 8-bit Fibonacci step, taps 8,6,5,4
    function automatic logic [7:0] lfsrNext(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

endpackage

// File: rtl/btn_capture.sv
// rtl/btn_capture.sv - pushbutton synchronizer, rising-edge detect and W1C sticky press flags
module btn_capture
    import dmem_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic [NBTN-1:0] btnRaw,
    input  logic [NBTN-1:0] clrMask,
    output logic [NBTN-1:0] btnLvl,
    output logic [NBTN-1:0] btnStat
);

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] prevLvl;
    logic [NBTN-1:0] rise;

    assign rise   = sync2 & ~prevLvl;
    assign btnLvl = sync2;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            sync1   <= '0;
            sync2   <= '0;
            prevLvl <= '0;
            btnStat <= '0;
        end else begin
            sync1   <= btnRaw;
            sync2   <= sync1;
            prevLvl <= sync2;
            // OR-ing the new edge after the clear makes a simultaneous press win
            btnStat <= (btnStat & ~clrMask) | rise;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - 240-byte RAM plus buttons, LFSR, seconds timer, LED and cursor MMIO
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int         TICK_DIV  = 50_000_000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic [7:0]      ADDR,
    input  logic [7:0]      WDATA,
    input  logic            MW,
    output logic [7:0]      RDATA,
    input  logic [NBTN-1:0] BTN,
    output logic [7:0]      LED,
    output logic [7:0]      CURSOR
);

    localparam int         PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] SEED_SAFE = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0]         mem [0:RAM_TOP];
    logic [7:0]         lfsr;
    logic [7:0]         timer;
    logic [PRESC_W-1:0] presc;
    logic [NBTN-1:0]    btnLvl;
    logic [NBTN-1:0]    btnStat;
    logic [NBTN-1:0]    clrMask;
    logic               isRam;

    assign isRam   = (ADDR <= RAM_TOP);
    assign clrMask = (MW && ADDR == A_BTN_STAT) ? WDATA[NBTN-1:0] : '0;

    btn_capture u_btn (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .btnRaw  (BTN),
        .clrMask (clrMask),
        .btnLvl  (btnLvl),
        .btnStat (btnStat)
    );

    // RAM has no reset, so a strobe during reset is masked explicitly
    always_ff @(posedge CLK) begin
        if (MW && isRam && RESET_L) begin
            mem[ADDR] <= WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            lfsr   <= SEED_SAFE;
            timer  <= 8'h00;
            presc  <= '0;
            LED    <= 8'h00;
            CURSOR <= 8'h00;
        end else begin
            if (MW && ADDR == A_RAND) begin
                lfsr <= (WDATA == 8'h00) ? 8'h01 : WDATA;
            end else begin
                lfsr <= lfsrNext(lfsr);
            end

            if (MW && ADDR == A_TIMER) begin
                timer <= WDATA;
                presc <= '0;
            end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
                timer <= timer + 8'd1;
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end

            if (MW && ADDR == A_LED) begin
                LED <= WDATA;
            end
            if (MW && ADDR == A_CURSOR) begin
                CURSOR <= WDATA;
            end
        end
    end

    always_comb begin
        RDATA = 8'h00;
        if (isRam) begin
            RDATA = mem[ADDR];
        end else begin
            case (ADDR)
                A_BTN_STAT: RDATA = {{(8-NBTN){1'b0}}, btnStat};
                A_BTN_LVL:  RDATA = {{(8-NBTN){1'b0}}, btnLvl};
                A_RAND:     RDATA = lfsr;
                A_TIMER:    RDATA = timer;
                A_LED:      RDATA = LED;
                A_CURSOR:   RDATA = CURSOR;
                default:    RDATA = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - self-checking bench for dmem_mmio
module tb_dmem_mmio;
    import dmem_pkg::*;

    logic            CLK;
    logic            RESET_L;
    logic [7:0]      ADDR;
    logic [7:0]      WDATA;
    logic            MW;
    logic [7:0]      RDATA;
    logic [NBTN-1:0] BTN;
    logic [7:0]      LED;
    logic [7:0]      CURSOR;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expQ [$];

    typedef struct {
        logic       mw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [17];

    dmem_mmio #(.TICK_DIV(4), .LFSR_SEED(8'hA5)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .MW      (MW),
        .RDATA   (RDATA),
        .BTN     (BTN),
        .LED     (LED),
        .CURSOR  (CURSOR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic rdCheck(input string nm, input logic [7:0] a, input logic [7:0] exp);
        ADDR = a;
        MW   = 1'b0;
        expQ.push_back(exp);
        #1;
        chk(nm, RDATA, expQ.pop_front());
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR  = a;
        WDATA = d;
        MW    = 1'b1;
        @(posedge CLK);
        #1;
        MW = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 8'h3C, 8'h00};
        vecs[1]  = '{1'b1, 8'hEF, 8'h5A, 8'h00};
        vecs[2]  = '{1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[3]  = '{1'b0, 8'hEF, 8'h00, 8'h5A};
        vecs[4]  = '{1'b0, 8'hF8, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 8'hF4, 8'h81, 8'h00};
        vecs[6]  = '{1'b1, 8'hF5, 8'h23, 8'h00};
        vecs[7]  = '{1'b0, 8'hF4, 8'h00, 8'h81};
        vecs[8]  = '{1'b0, 8'hF5, 8'h00, 8'h23};
        vecs[9]  = '{1'b1, 8'hF8, 8'h77, 8'h00};
        vecs[10] = '{1'b0, 8'hF8, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 8'h00, 8'h11, 8'h00};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 8'h11};
        vecs[14] = '{1'b1, 8'hF1, 8'hFF, 8'h00};
        vecs[15] = '{1'b0, 8'hF1, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 8'h10, 8'h00, 8'h3C};

        RESET_L = 1'b1;
        MW      = 1'b0;
        ADDR    = A_RAND;
        WDATA   = 8'h00;
        BTN     = '0;
        #1 RESET_L = 1'b0;
        #1;
        rdCheck("rst_rand", A_RAND, 8'hA5);
        rdCheck("rst_timer", A_TIMER, 8'h00);
        rdCheck("rst_btn_stat", A_BTN_STAT, 8'h00);
        chk("rst_led", LED, 8'h00);
        chk("rst_cursor", CURSOR, 8'h00);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_L = 1'b1;
        rdCheck("rand_seed", A_RAND, 8'hA5);
        rdCheck("timer_start", A_TIMER, 8'h00);
        @(posedge CLK); #1;
        rdCheck("rand_step", A_RAND, 8'h4A);
        repeat (2) @(posedge CLK); #1;
        rdCheck("timer_3cyc", A_TIMER, 8'h00);
        @(posedge CLK); #1;
        rdCheck("timer_4cyc", A_TIMER, 8'h01);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].mw) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                @(negedge CLK);
                rdCheck($sformatf("vec%0d_addr%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
            end
        end
        chk("led_out", LED, 8'h81);
        chk("cursor_out", CURSOR, 8'h23);

        wr(A_RAND, 8'h00);
        rdCheck("reseed_zero", A_RAND, 8'h01);
        @(posedge CLK); #1;
        rdCheck("reseed_step", A_RAND, 8'h02);
        wr(A_RAND, 8'hA5);
        rdCheck("reseed_a5", A_RAND, 8'hA5);
        @(posedge CLK); #1;
        rdCheck("reseed_a5_step", A_RAND, 8'h4A);

        wr(A_TIMER, 8'hFF);
        rdCheck("timer_load", A_TIMER, 8'hFF);
        repeat (3) @(posedge CLK); #1;
        rdCheck("timer_hold", A_TIMER, 8'hFF);
        @(posedge CLK); #1;
        rdCheck("timer_wrap", A_TIMER, 8'h00);

        @(negedge CLK);
        BTN[BTN_UP] = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        rdCheck("btn_stat_2edges", A_BTN_STAT, 8'h00);
        rdCheck("btn_lvl", A_BTN_LVL, 8'h01);
        @(posedge CLK); #1;
        rdCheck("btn_stat_3edges", A_BTN_STAT, 8'h01);
        @(posedge CLK);
        @(negedge CLK);
        BTN = '0;
        wr(A_BTN_STAT, 8'h00);
        rdCheck("btn_w0_keep", A_BTN_STAT, 8'h01);
        wr(A_BTN_STAT, 8'h01);
        rdCheck("btn_w1c", A_BTN_STAT, 8'h00);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        BTN[BTN_UP] = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        ADDR  = A_BTN_STAT;
        WDATA = 8'h01;
        MW    = 1'b1;
        @(posedge CLK); #1;
        MW = 1'b0;
        rdCheck("btn_set_wins", A_BTN_STAT, 8'h01);
        @(negedge CLK);
        BTN = '0;

        wr(A_LED, 8'h81);
        wr(A_CURSOR, 8'h23);
        chk("led_pre_reset", LED, 8'h81);
        @(negedge CLK);
        #2 RESET_L = 1'b0;
        #1;
        chk("led_async_reset", LED, 8'h00);
        chk("cursor_async_reset", CURSOR, 8'h00);
        ADDR  = 8'h10;
        WDATA = 8'hFF;
        MW    = 1'b1;
        @(posedge CLK); #1;
        MW = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        rdCheck("ram_kept", 8'h10, 8'h3C);
        rdCheck("rand_after_reset", A_RAND, 8'hA5);
        rdCheck("btn_after_reset", A_BTN_STAT, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
